mem_hier_ctrl: RTL

Sequencing controller for one lookup through the L1 cache, the L2 cache and main memory.
- Accepts one CPU read request at a time and drives the shared address into both caches.
- Walks the request L1 → L2 → memory and fills the upper levels on a miss: L2 then L1 on a memory fetch, L1 only on an L2 hit.
- Returns the data with its source level and keeps saturating hit statistics.
- Sits between the CPU request port and the l1_cache / l2_cache / memory read channel.

---
 rtl/mem_hier_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_hier_ctrl.sv
// Sequencing controller for one read through L1 -> L2 -> main memory, with
// upper-level fills on a miss, a memory timeout and saturating hit statistics.
module mem_hier_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [1:0]        resp_src,
  output logic              resp_err,
  output logic [ADDR_W-1:0] l1_addr,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l1_hit,
  input  logic              l2_hit,
  input  logic [DATA_W-1:0] l1_data,
  input  logic [DATA_W-1:0] l2_data,
  output logic              l1_promote,
  output logic              l2_promote,
  output logic [DATA_W-1:0] l1_promo_data,
  output logic [DATA_W-1:0] l2_promo_data,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  l1_hit_cnt,
  output logic [CNT_W-1:0]  l2_hit_cnt,
  output logic [CNT_W-1:0]  mem_cnt,
  output logic              busy
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_L1_LOOK  = 3'd1,
    S_L2_LOOK  = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_PROM_L2  = 3'd5,
    S_PROM_L1  = 3'd6,
    S_RESP     = 3'd7
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_data_q;
  logic [1:0]        r_src;
  logic              r_err;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_mem_rd_valid;
  logic              r_l1_promote;
  logic              r_l2_promote;
  logic [TW-1:0]     r_tmo;
  logic [CNT_W-1:0]  r_l1_cnt;
  logic [CNT_W-1:0]  r_l2_cnt;
  logic [CNT_W-1:0]  r_mem_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr_q       <= '0;
      r_data_q       <= '0;
      r_src          <= '0;
      r_err          <= 1'b0;
      r_req_ready    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_mem_rd_valid <= 1'b0;
      r_l1_promote   <= 1'b0;
      r_l2_promote   <= 1'b0;
      r_tmo          <= '0;
      r_l1_cnt       <= '0;
      r_l2_cnt       <= '0;
      r_mem_cnt      <= '0;
    end else begin
      r_l1_promote <= 1'b0;
      r_l2_promote <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_addr_q    <= req_addr;
            r_req_ready <= 1'b0;
            r_state     <= S_L1_LOOK;
          end
        end
        S_L1_LOOK: begin
          if (l1_hit) begin
            r_data_q     <= l1_data;
            r_src        <= 2'd0;
            r_l1_cnt     <= sat_inc(r_l1_cnt);
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_state <= S_L2_LOOK;
          end
        end
        S_L2_LOOK: begin
          if (l2_hit) begin
            r_data_q     <= l2_data;
            r_src        <= 2'd1;
            r_l2_cnt     <= sat_inc(r_l2_cnt);
            r_l1_promote <= 1'b1;
            r_state      <= S_PROM_L1;
          end else begin
            r_mem_rd_valid <= 1'b1;
            r_state        <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_rd_ready) begin
            r_mem_rd_valid <= 1'b0;
            r_tmo          <= '0;
            r_state        <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            r_data_q     <= mem_rsp_data;
            r_src        <= 2'd2;
            r_mem_cnt    <= sat_inc(r_mem_cnt);
            r_l2_promote <= 1'b1;
            r_state      <= S_PROM_L2;
          end else if (r_tmo == TW'(MEM_TIMEOUT - 1)) begin
            r_err        <= 1'b1;
            r_data_q     <= '0;
            r_src        <= 2'd2;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_PROM_L2: begin
          r_l1_promote <= 1'b1;
          r_state      <= S_PROM_L1;
        end
        S_PROM_L1: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Later assignment wins, so a clear beats any same-cycle increment.
      if (clr_stats) begin
        r_l1_cnt  <= '0;
        r_l2_cnt  <= '0;
        r_mem_cnt <= '0;
      end
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_data_q;
  assign resp_src      = r_src;
  assign resp_err      = r_err;
  assign l1_addr       = r_addr_q;
  assign l2_addr       = r_addr_q;
  assign mem_addr      = r_addr_q;
  assign mem_rd_valid  = r_mem_rd_valid;
  assign l1_promote    = r_l1_promote;
  assign l2_promote    = r_l2_promote;
  assign l1_promo_data = r_data_q;
  assign l2_promo_data = r_data_q;
  assign l1_hit_cnt    = r_l1_cnt;
  assign l2_hit_cnt    = r_l2_cnt;
  assign mem_cnt       = r_mem_cnt;
  assign busy          = (r_state != S_IDLE);

endmodule
